regn_pipe: RTL and testbench

Parametrised elastic register pipeline. It is the successor to the single-stage enable register: N bits wide, DEPTH stages deep, with valid/ready flow control on both sides, a global hold enable and a synchronous flush. It sits between producer and consumer datapath blocks that need registered retiming with back-pressure instead of a free-running enable.

---
 rtl/regn_pipe_if.sv | 70 +++++++
 rtl/regn_pipe.sv | 140 ++++++++++++++
 tb/tb_regn_pipe.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regn_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : regn_pipe_if
//  Description : Producer/consumer handshake bundle for regn_pipe.
//                master : the side that drives en/flush/in_valid/D/out_ready
//                         and observes in_ready/out_valid/q (and count).
//                slave  : the pipeline itself.
//                Signals:
//                  en        global enable, 0 freezes every stage
//                  flush     synchronous clear of all stage valid bits
//                  in_valid  producer presents a word on D
//                  in_ready  pipeline accepts D this cycle
//                  D         input data, N bits
//                  out_valid last stage holds a valid word
//                  out_ready consumer accepts q this cycle
//                  q         data of last stage, N bits
//                  count     occupancy, only with REGN_PIPE_COUNT_EN defined
//  Config      : REGN_PIPE_COUNT_EN adds the count signal.
//  Revision    : 1.0  initial release
// ============================================================================
interface regn_pipe_if #(
    parameter int N     = 8,
    parameter int DEPTH = 2
);

    logic         en;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] D;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] q;
`ifdef REGN_PIPE_COUNT_EN
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    logic [c_cnt_w-1:0] count;
`endif

    modport master (
        output en,
        output flush,
        output in_valid,
        output D,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  q
`ifdef REGN_PIPE_COUNT_EN
        ,
        input  count
`endif
    );

    modport slave (
        input  en,
        input  flush,
        input  in_valid,
        input  D,
        input  out_ready,
        output in_ready,
        output out_valid,
        output q
`ifdef REGN_PIPE_COUNT_EN
        ,
        output count
`endif
    );

endinterface
`default_nettype wire

// File: rtl/regn_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : regn_pipe
//  Description : Parametrised elastic register pipeline, N bits wide and
//                DEPTH stages deep, with valid/ready flow control on both
//                sides, a global hold enable and a synchronous flush.
//                Bubbles collapse: an empty stage always accepts a word.
//  Ports       : clk   rising-edge clock
//                rest  asynchronous active-high reset (clears valid and data)
//                pipe  regn_pipe_if.slave handshake bundle (en, flush,
//                      in_valid/in_ready/D, out_valid/out_ready/q, count)
//  Parameters  : N     data width (>= 1)
//                DEPTH number of register stages (>= 1)
//  Config      : REGN_PIPE_COUNT_EN defined -> registered occupancy counter
//                driven onto pipe.count; undefined -> no counter logic.
//  Revision    : 1.0  initial release
// ============================================================================
module regn_pipe #(
    parameter int N     = 8,
    parameter int DEPTH = 2
) (
    input  wire logic   clk,
    input  wire logic   rest,
    regn_pipe_if.slave  pipe
);

    // ------------------------------------------------------------------
    // Stage state: stage 0 is the input side, DEPTH-1 the output side.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] r_v;
    logic [N-1:0]     r_d [DEPTH];

    logic [DEPTH-1:0] w_rdy;     // stage can take a word this cycle
    logic [DEPTH-1:0] w_load;    // stage captures a word at the next edge
    logic [DEPTH-1:0] w_leave;   // stage hands its word on at the next edge
    logic [N-1:0]     w_src [DEPTH];
    logic             w_acc;
    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;

    // ------------------------------------------------------------------
    // Readiness chain. A stage is ready when it, or any stage downstream
    // of it, is empty, or when the consumer is taking the last word.
    // Accumulated in a local variable walking from the output side so the
    // chain has no self-referencing vector.
    // ------------------------------------------------------------------
    always_comb begin : p_ready
        w_rdy = '0;
        w_acc = pipe.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_acc    = w_acc | ~r_v[i];
            w_rdy[i] = w_acc;
        end
    end

    // Flush wins over everything: nothing enters while it is asserted.
    assign w_in_ready = pipe.en & ~pipe.flush & w_rdy[0];
    assign w_push     = pipe.in_valid & w_in_ready;
    // The pop is seen by the consumer even in a flush cycle; the stage is
    // cleared by the flush either way.
    assign w_pop      = r_v[DEPTH-1] & pipe.out_ready & pipe.en;

    // ------------------------------------------------------------------
    // Per-stage load / leave decode and data source selection.
    // Inter-stage moves are suppressed during flush so d[] keeps its value.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign w_load[gi] = w_push;
            assign w_src[gi]  = pipe.D;
        end else begin : g_body
            assign w_load[gi] = r_v[gi-1] & w_rdy[gi] & pipe.en & ~pipe.flush;
            assign w_src[gi]  = r_d[gi-1];
        end

        if (gi == DEPTH - 1) begin : g_tail
            assign w_leave[gi] = w_pop;
        end else begin : g_mid
            assign w_leave[gi] = w_load[gi+1];
        end
    end

    // ------------------------------------------------------------------
    // Stage registers. A stage stays valid if it keeps its word or gets a
    // new one; data registers change only on a load.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            r_v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_d[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe.flush) begin
                    r_v[i] <= 1'b0;
                end else begin
                    r_v[i] <= w_load[i] | (r_v[i] & ~w_leave[i]);
                end
                if (w_load[i]) begin
                    r_d[i] <= w_src[i];
                end
            end
        end
    end

    assign pipe.in_ready  = w_in_ready;
    assign pipe.out_valid = r_v[DEPTH-1];
    assign pipe.q         = r_d[DEPTH-1];

    // ------------------------------------------------------------------
    // Optional occupancy counter, updated at the same edge as r_v.
    // A push and a pop in the same cycle cancel out.
    // ------------------------------------------------------------------
`ifdef REGN_PIPE_COUNT_EN
    localparam int                 c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            r_count <= '0;
        end else if (pipe.flush) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + c_one;
        end else if (w_pop && !w_push) begin
            r_count <= r_count - c_one;
        end
    end

    assign pipe.count = r_count;
`else
    // Occupancy tracking not built; the handshake alone carries flow control.
`endif

endmodule
`default_nettype wire

// File: tb/tb_regn_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regn_pipe
//  Description : Self-checking bench for regn_pipe. Two instances are
//                exercised: N=8/DEPTH=2 and N=16/DEPTH=1. Each instance is
//                compared every cycle against a queue model that tracks each
//                word in flight with its stage position.
//  Config      : count is checked only when REGN_PIPE_COUNT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regn_pipe;

    localparam int NA = 8;
    localparam int DA = 2;
    localparam int NB = 16;
    localparam int DB = 1;

    logic clk = 1'b0;
    logic rest;

    regn_pipe_if #(.N(NA), .DEPTH(DA)) bus_a ();
    regn_pipe_if #(.N(NB), .DEPTH(DB)) bus_b ();

    regn_pipe #(.N(NA), .DEPTH(DA)) dut_a (.clk(clk), .rest(rest), .pipe(bus_a));
    regn_pipe #(.N(NB), .DEPTH(DB)) dut_b (.clk(clk), .rest(rest), .pipe(bus_b));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model: per instance k, an ordered list of words (oldest
    // first) with the stage index each one currently sits in.
    // ------------------------------------------------------------------
    logic [15:0] m_d [2][8];
    int          m_p [2][8];
    int          m_n [2];
    logic [15:0] m_q [2];

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_n[k] = 0;
            m_q[k] = '0;
        end
    endtask

    // Some stage is free whenever fewer words than stages are held.
    function automatic bit m_ready(input int k, input int dep, input logic en,
                                   input logic fl, input logic ordy);
        return en && !fl && ((m_n[k] < dep) || ordy);
    endfunction

    function automatic bit m_valid(input int k, input int dep);
        return (m_n[k] > 0) && (m_p[k][0] == dep - 1);
    endfunction

    task automatic m_step(input int k, input int dep, input logic en, input logic fl,
                          input logic iv, input logic [15:0] din, input logic ordy);
        bit rdy;
        int lim;
        rdy = m_ready(k, dep, en, fl, ordy);
        if (fl) begin
            m_n[k] = 0;
        end else if (en) begin
            if (m_valid(k, dep) && ordy) begin
                for (int j = 0; j < m_n[k] - 1; j++) begin
                    m_d[k][j] = m_d[k][j+1];
                    m_p[k][j] = m_p[k][j+1];
                end
                m_n[k]--;
            end
            // Every word advances one stage if the slot ahead is free.
            lim = dep - 1;
            for (int j = 0; j < m_n[k]; j++) begin
                if (m_p[k][j] < lim) m_p[k][j]++;
                lim = m_p[k][j] - 1;
            end
            if (iv && rdy) begin
                m_d[k][m_n[k]] = din;
                m_p[k][m_n[k]] = 0;
                m_n[k]++;
            end
        end
        if (m_valid(k, dep)) m_q[k] = m_d[k][0];
    endtask

    task automatic check_a(input string ph);
        check_val({ph, "/a_in_ready"}, 32'(bus_a.in_ready),
                  32'(m_ready(0, DA, bus_a.en, bus_a.flush, bus_a.out_ready)));
        check_val({ph, "/a_out_valid"}, 32'(bus_a.out_valid), 32'(m_valid(0, DA)));
        check_val({ph, "/a_q"}, 32'(bus_a.q), 32'(m_q[0]));
`ifdef REGN_PIPE_COUNT_EN
        check_val({ph, "/a_count"}, 32'(bus_a.count), 32'(m_n[0]));
`endif
    endtask

    task automatic check_b(input string ph);
        check_val({ph, "/b_in_ready"}, 32'(bus_b.in_ready),
                  32'(m_ready(1, DB, bus_b.en, bus_b.flush, bus_b.out_ready)));
        check_val({ph, "/b_out_valid"}, 32'(bus_b.out_valid), 32'(m_valid(1, DB)));
        check_val({ph, "/b_q"}, 32'(bus_b.q), 32'(m_q[1]));
`ifdef REGN_PIPE_COUNT_EN
        check_val({ph, "/b_count"}, 32'(bus_b.count), 32'(m_n[1]));
`endif
    endtask

    // Compare at the falling edge, then advance the model at the rising edge.
    task automatic tick(input string ph);
        @(negedge clk);
        check_a(ph);
        check_b(ph);
        @(posedge clk);
        if (rest) begin
            m_reset();
        end else begin
            m_step(0, DA, bus_a.en, bus_a.flush, bus_a.in_valid, 16'(bus_a.D), bus_a.out_ready);
            m_step(1, DB, bus_b.en, bus_b.flush, bus_b.in_valid, bus_b.D, bus_b.out_ready);
        end
        #1;
    endtask

    task automatic drv_a(input logic en, input logic fl, input logic iv,
                         input logic [7:0] d, input logic ordy);
        bus_a.en = en; bus_a.flush = fl; bus_a.in_valid = iv;
        bus_a.D = d;   bus_a.out_ready = ordy;
        #1;
    endtask

    task automatic drv_b(input logic en, input logic fl, input logic iv,
                         input logic [15:0] d, input logic ordy);
        bus_b.en = en; bus_b.flush = fl; bus_b.in_valid = iv;
        bus_b.D = d;   bus_b.out_ready = ordy;
        #1;
    endtask

    logic [7:0] hold_q;
    logic       hold_v;

    initial begin
        rest = 1'b1;
        m_reset();
        drv_a(1, 0, 0, 8'h00, 0);
        drv_b(1, 0, 0, 16'h0000, 0);
        tick("reset");
        tick("reset");
        rest = 1'b0;
        #1;
        check_val("reset/a_in_ready_after_release", 32'(bus_a.in_ready), 32'd1);
        tick("idle");

        // Streaming: 0x01 visible right after the second edge.
        drv_a(1, 0, 1, 8'h01, 1); tick("stream");
        drv_a(1, 0, 1, 8'h02, 1); tick("stream");
        check_val("stream/q_01", 32'(bus_a.q), 32'h01);
        check_val("stream/v_01", 32'(bus_a.out_valid), 32'd1);
        drv_a(1, 0, 1, 8'h04, 1); tick("stream");
        check_val("stream/q_02", 32'(bus_a.q), 32'h02);
        drv_a(1, 0, 1, 8'h08, 1); tick("stream");
        check_val("stream/q_04", 32'(bus_a.q), 32'h04);
        drv_a(1, 0, 0, 8'h00, 1); tick("stream");
        check_val("stream/q_08", 32'(bus_a.q), 32'h08);
        tick("drain");
        tick("drain");

        // Back-pressure.
        drv_a(1, 0, 1, 8'h11, 0); tick("bp");
        drv_a(1, 0, 1, 8'h22, 0); tick("bp");
        drv_a(1, 0, 1, 8'h33, 0);
        check_val("bp/in_ready_full", 32'(bus_a.in_ready), 32'd0);
        check_val("bp/q_11", 32'(bus_a.q), 32'h11);
`ifdef REGN_PIPE_COUNT_EN
        check_val("bp/count_2", 32'(bus_a.count), 32'd2);
`endif
        tick("bp");
        drv_a(1, 0, 1, 8'h33, 1);
        check_val("bp/in_ready_same_cycle", 32'(bus_a.in_ready), 32'd1);
        tick("bp");
        check_val("bp/q_22", 32'(bus_a.q), 32'h22);
        drv_a(1, 0, 0, 8'h00, 1); tick("bp");
        check_val("bp/q_33", 32'(bus_a.q), 32'h33);
        tick("drain");

        // Hold with en=0.
        drv_a(1, 0, 1, 8'h44, 1); tick("hold");
        drv_a(1, 0, 1, 8'h45, 1); tick("hold");
        drv_a(0, 0, 1, 8'h46, 1);
        hold_q = bus_a.q;
        hold_v = bus_a.out_valid;
        for (int i = 0; i < 3; i++) begin
            check_val("hold/in_ready", 32'(bus_a.in_ready), 32'd0);
            check_val("hold/q_44", 32'(hold_q), 32'h44);
            tick("hold");
            check_val("hold/q_stable", 32'(bus_a.q), 32'(hold_q));
            check_val("hold/v_stable", 32'(bus_a.out_valid), 32'(hold_v));
        end
        drv_a(1, 0, 1, 8'h46, 1); tick("hold");
        check_val("hold/q_45", 32'(bus_a.q), 32'h45);
        drv_a(1, 0, 0, 8'h00, 1); tick("hold");
        check_val("hold/q_46", 32'(bus_a.q), 32'h46);
        tick("drain");

        // Flush with two words held.
        drv_a(1, 0, 1, 8'h66, 0); tick("flush");
        drv_a(1, 0, 1, 8'h77, 0); tick("flush");
        drv_a(1, 1, 1, 8'h55, 0);
        check_val("flush/in_ready", 32'(bus_a.in_ready), 32'd0);
        tick("flush");
        drv_a(1, 0, 0, 8'h00, 1);
        check_val("flush/out_valid", 32'(bus_a.out_valid), 32'd0);
`ifdef REGN_PIPE_COUNT_EN
        check_val("flush/count", 32'(bus_a.count), 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            check_val("flush/no_55", 32'(bus_a.q == 8'h55), 32'd0);
            tick("flush");
        end

        // DEPTH=1, N=16.
        drv_b(1, 0, 1, 16'hBEEF, 0); tick("depth1");
        check_val("depth1/out_valid", 32'(bus_b.out_valid), 32'd1);
        check_val("depth1/q", 32'(bus_b.q), 32'hBEEF);
        drv_b(1, 0, 0, 16'h0000, 1); tick("depth1");

        // Reset mid-stream with two words in flight.
        drv_a(1, 0, 1, 8'hA1, 0); tick("midrst");
        drv_a(1, 0, 1, 8'hA2, 0); tick("midrst");
        rest = 1'b1;
        m_reset();
        #1;
        check_val("midrst/out_valid", 32'(bus_a.out_valid), 32'd0);
        check_val("midrst/q", 32'(bus_a.q), 32'h00);
`ifdef REGN_PIPE_COUNT_EN
        check_val("midrst/count", 32'(bus_a.count), 32'd0);
`endif
        tick("midrst");
        rest = 1'b0;
        drv_a(1, 0, 1, 8'h00, 1);
        check_val("midrst/in_ready", 32'(bus_a.in_ready), 32'd1);
        drv_a(1, 0, 0, 8'h00, 1);
        tick("midrst");

        // Randomised traffic on both instances.
        for (int c = 0; c < 600; c++) begin
            rest = ($urandom_range(0, 199) == 0);
            if (rest) m_reset();
            drv_a($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6);
            drv_b($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 6);
            tick("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
